// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, byte indexing helpers and the
// front-half round controller state encoding.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } round_state_e;

    // MSB bit position of byte k; byte 0 sits at the top of the vector.
    function automatic int byte_msb(input int k);
        return AES_STATE_W - 1 - 8 * k;
    endfunction

    // Source byte index feeding destination byte dst under InvShiftRows.
    // Row r of the destination column c' came from column (c' - r) mod 4.
    function automatic int inv_shift_rows_src(input int dst);
        int r;
        int c;
        r = dst % 4;
        c = dst / 4;
        return 4 * ((c + 4 - r) % 4) + r;
    endfunction

    function automatic logic [AES_STATE_W-1:0] inv_shift_rows(input logic [AES_STATE_W-1:0] s);
        logic [AES_STATE_W-1:0] t;
        t = '0;
        for (int dst = 0; dst < AES_BYTES; dst++) begin
            t[byte_msb(dst) -: 8] = s[byte_msb(inv_shift_rows_src(dst)) -: 8];
        end
        return t;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module inv_sbox (
    input  logic [7:0] sub_byte,
    output logic [7:0] inv_byte
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign inv_byte = INV_SBOX[sub_byte];

endmodule

// File: rtl/inv_round_front.sv
// Front half of an AES inverse round: InvShiftRows on load, iterative
// InvSubBytes (BYTES_PER_CYCLE bytes per clock), AddRoundKey on the last chunk.
//
// state | meaning
// IDLE  | ready for a new state; accept loads shifted state and key
// SUB   | substituting one chunk of bytes per clock
// DONE  | result presented on state_out until out_ready
module inv_round_front
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4    // 1, 2, 4, 8 or 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NUM_CHUNKS = AES_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    round_state_e state_q;
    round_state_e state_d;

    logic [7:0]         work_q   [AES_BYTES];
    logic [7:0]         sub_work [AES_BYTES];
    logic [7:0]         shifted  [AES_BYTES];
    logic [7:0]         sbox_in  [BYTES_PER_CYCLE];
    logic [7:0]         sbox_out [BYTES_PER_CYCLE];
    logic [127:0]       key_q;
    logic [127:0]       state_out_q;
    logic [127:0]       result;
    logic [127:0]       shifted_flat;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         chunk_base;
    logic               idle_ready;
    logic               accept;
    logic               last_chunk;

    assign in_ready   = idle_ready & ~rst;
    assign state_out  = state_out_q;
    assign chunk_base = 4'(int'(cnt_q) * BYTES_PER_CYCLE);

    // Next-state and handshake decode
    always_comb begin
        state_d    = state_q;
        idle_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_chunk = 1'b0;
        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                busy = 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    last_chunk = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset overrides every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Unpack the row-shifted input into a byte array for the work register
    always_comb begin
        shifted_flat = inv_shift_rows(state_in);
        for (int k = 0; k < AES_BYTES; k++) begin
            shifted[k] = shifted_flat[byte_msb(k) -: 8];
        end
    end

    // Select the bytes of the current chunk for the S-box bank
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sbox_in[j] = work_q[chunk_base + 4'(j)];
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .sub_byte (sbox_in[g]),
            .inv_byte (sbox_out[g])
        );
    end

    // Merge the substituted chunk back into the work bytes
    always_comb begin
        sub_work = work_q;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sub_work[chunk_base + 4'(j)] = sbox_out[j];
        end
    end

    // AddRoundKey on the fully substituted state (used on the last chunk only)
    always_comb begin
        result = '0;
        for (int k = 0; k < AES_BYTES; k++) begin
            result[byte_msb(k) -: 8] = sub_work[k] ^ key_q[byte_msb(k) -: 8];
        end
    end

    // Datapath registers: load on accept, substitute in SUB, capture result
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < AES_BYTES; k++) begin
                work_q[k] <= 8'h00;
            end
            key_q       <= '0;
            cnt_q       <= '0;
            state_out_q <= '0;
        end else if (accept) begin
            work_q <= shifted;
            key_q  <= round_key;
            cnt_q  <= '0;
        end else if (state_q == SUB) begin
            work_q <= sub_work;
            if (last_chunk) begin
                cnt_q       <= '0;
                state_out_q <= result;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inv_round_front.sv
// Bench for inv_round_front: three instances (B=4, B=1, B=16) share the
// stimulus; results are compared to a GF(2^8)-derived reference model.
module tb_inv_round_front;

    localparam logic [127:0] C1_ST  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_KEY = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] C1_EXP = 128'he9f74eec023020f61bf2ccf2353c21c7;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         rdy  [3];
    logic         vld  [3];
    logic         bsy  [3];
    logic [127:0] dout [3];

    int lat_exp [3] = '{4, 16, 1};
    int bsel    [3] = '{4, 1, 16};

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] isbox_m [256];

    always #5 clk = ~clk;

    inv_round_front #(.BYTES_PER_CYCLE(4)) u_b4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .state_in(state_in), .round_key(round_key), .out_valid(vld[0]),
        .out_ready(out_ready), .state_out(dout[0]), .busy(bsy[0])
    );
    inv_round_front #(.BYTES_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .state_in(state_in), .round_key(round_key), .out_valid(vld[1]),
        .out_ready(out_ready), .state_out(dout[1]), .busy(bsy[1])
    );
    inv_round_front #(.BYTES_PER_CYCLE(16)) u_b16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .state_in(state_in), .round_key(round_key), .out_valid(vld[2]),
        .out_ready(out_ready), .state_out(dout[2]), .busy(bsy[2])
    );

    typedef struct {
        string        name;
        logic [127:0] st;
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Forward S-box from the field inverse plus affine map, then inverted.
    task automatic build_model();
        logic [7:0] inv, s, x8;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isbox_m[s] = x8;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key);
        logic [7:0]   sh [16];
        logic [127:0] o;
        int r, c;
        for (int k = 0; k < 16; k++) begin
            r = k % 4;
            c = k / 4;
            sh[4 * ((c + r) % 4) + r] = st[127 - 8 * k -: 8];
        end
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8 * k -: 8] = isbox_m[sh[k]] ^ key[127 - 8 * k -: 8];
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Accept one state on all instances with out_ready=1 and check each one.
    task automatic run_one(input string name, input logic [127:0] st,
                           input logic [127:0] key, input logic [127:0] exp);
        int           guard;
        int           lat [3];
        int           hi  [3];
        logic [127:0] got [3];
        guard = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check({name, "_ready_timeout"}, 128'(guard), 128'(0));
        out_ready = 1'b1;
        state_in  = st;
        round_key = key;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        state_in  = {$urandom, $urandom, $urandom, $urandom};
        round_key = {$urandom, $urandom, $urandom, $urandom};
        for (int d = 0; d < 3; d++) begin
            lat[d] = -1; hi[d] = 0; got[d] = '0;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) check({name, "_busy_b4"}, 128'(bsy[0]), 128'(1));
            for (int d = 0; d < 3; d++) begin
                if (vld[d]) begin
                    if (lat[d] < 0) begin
                        lat[d] = k;
                        got[d] = dout[d];
                    end
                    hi[d]++;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_b%0d_data", name, bsel[d]), got[d], exp);
            check($sformatf("%s_b%0d_latency", name, bsel[d]), 128'(lat[d]), 128'(lat_exp[d]));
            check($sformatf("%s_b%0d_valid_cycles", name, bsel[d]), 128'(hi[d]), 128'(1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [4];
        logic [127:0] st, key, b_st, b_key, b_exp;
        logic [127:0] outs [$];
        int           guard, n_acc, cyc, seen;
        int           acc_edge [2];
        logic         pre_rdy;

        build_model();

        tbl[0] = '{"c1",       C1_ST,  C1_KEY,  C1_EXP};
        tbl[1] = '{"zero",     '0,     '0,      {16{8'h52}}};
        tbl[2] = '{"zero_ones", '0,    '1,      {16{8'had}}};
        tbl[3] = '{"ones_zero", '1,    '0,      {16{8'h7d}}};

        // Reset values, including in_ready low during the reset cycle
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        state_in = '0; round_key = '0;
        tick();
        check("reset_in_ready", 128'(rdy[0]), 128'(0));
        check("reset_out_valid", 128'(vld[0]), 128'(0));
        check("reset_busy", 128'(bsy[0]), 128'(0));
        check("reset_state_out", dout[0], '0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 128'(rdy[0]), 128'(1));

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_one(tbl[i].name, tbl[i].st, tbl[i].key, tbl[i].exp);
        end

        // Random vectors against the model
        for (int i = 0; i < 10; i++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            run_one($sformatf("rand%0d", i), st, key, model(st, key));
        end

        // Backpressure: hold DONE for 5 cycles, stray in_valid ignored
        do_reset();
        out_ready = 1'b0;
        state_in  = C1_ST;
        round_key = C1_KEY;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!vld[0] && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_valid_rise", 128'(vld[0]), 128'(1));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_data", i), dout[0], C1_EXP);
            check($sformatf("bp_hold%0d_in_ready", i), 128'(rdy[0]), 128'(0));
            check($sformatf("bp_hold%0d_valid", i), 128'(vld[0]), 128'(1));
            if (i == 1) begin
                state_in  = {$urandom, $urandom, $urandom, $urandom};
                round_key = '1;
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 128'(vld[0]), 128'(0));
        check("bp_release_in_ready", 128'(rdy[0]), 128'(1));
        check("bp_release_data", dout[0], C1_EXP);
        tick(); tick(); tick();
        check("bp_stray_ignored_busy", 128'(bsy[0]), 128'(0));
        check("bp_stray_ignored_data", dout[0], C1_EXP);

        // Reset two edges after acceptance
        do_reset();
        out_ready = 1'b1;
        state_in  = C1_ST;
        round_key = C1_KEY;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready_low", 128'(rdy[0]), 128'(0));
        tick();
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 128'(rdy[0]), 128'(1));
        check("midrst_state_out", dout[0], '0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (vld[0]) seen = 1;
            tick();
        end
        check("midrst_no_output", 128'(seen), 128'(0));
        run_one("midrst_c1", C1_ST, C1_KEY, C1_EXP);

        // Back-to-back with in_valid held high
        do_reset();
        out_ready = 1'b1;
        b_st  = {$urandom, $urandom, $urandom, $urandom};
        b_key = {$urandom, $urandom, $urandom, $urandom};
        b_exp = model(b_st, b_key);
        state_in  = C1_ST;
        round_key = C1_KEY;
        in_valid  = 1'b1;
        n_acc = 0;
        cyc   = 0;
        acc_edge[0] = 0;
        acc_edge[1] = 0;
        while (outs.size() < 2 && cyc < 60) begin
            if (vld[0]) outs.push_back(dout[0]);
            pre_rdy = rdy[0] & in_valid;
            tick();
            cyc++;
            if (pre_rdy) begin
                if (n_acc < 2) acc_edge[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    state_in  = b_st;
                    round_key = b_key;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_accept_count", 128'(n_acc), 128'(2));
        check("b2b_accept_spacing", 128'(acc_edge[1] - acc_edge[0]), 128'(6));
        check("b2b_out_count", 128'(outs.size()), 128'(2));
        if (outs.size() >= 1) check("b2b_first", outs[0], C1_EXP);
        if (outs.size() >= 2) check("b2b_second", outs[1], b_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
